// File: rtl/ntt_layer_ctrl_if.sv
// Handshake and RAM-address bundle for the forward-NTT layer sequencer.
//   start_i / stall_i                    : requests into the sequencer
//   busy_o / done_o                      : transform status
//   rd_en_o, rd_addr_a/b_o, zeta_idx_o,
//   layer_o                              : butterfly issue (RAM read side)
//   wr_en_o, wr_addr_a/b_o               : delayed write-back side
// master = sequencer, slave = the datapath / RAM side that consumes it.
interface ntt_layer_ctrl_if #(
  parameter int LOG_N = 8
);
  logic             start_i;
  logic             stall_i;
  logic             busy_o;
  logic             done_o;
  logic             rd_en_o;
  logic [LOG_N-1:0] rd_addr_a_o;
  logic [LOG_N-1:0] rd_addr_b_o;
  logic [LOG_N-2:0] zeta_idx_o;
  logic [2:0]       layer_o;
  logic             wr_en_o;
  logic [LOG_N-1:0] wr_addr_a_o;
  logic [LOG_N-1:0] wr_addr_b_o;

  modport master (
    input  start_i, stall_i,
    output busy_o, done_o, rd_en_o, rd_addr_a_o, rd_addr_b_o, zeta_idx_o,
           layer_o, wr_en_o, wr_addr_a_o, wr_addr_b_o
  );

  modport slave (
    output start_i, stall_i,
    input  busy_o, done_o, rd_en_o, rd_addr_a_o, rd_addr_b_o, zeta_idx_o,
           layer_o, wr_en_o, wr_addr_a_o, wr_addr_b_o
  );
endinterface

// File: rtl/ntt_layer_ctrl.sv
// Sequencer for the in-place forward NTT (Q = 3329, N = 2^LOG_N).
// Walks LOG_N-1 layers of 2^(LOG_N-1) Cooley-Tukey butterflies through one
// shared pipelined butterfly unit, issuing read addresses and twiddle index,
// replaying the addresses LAT cycles later as write-back addresses, and
// draining the pipeline for LAT cycles between layers so that no read of a
// layer sees a stale value from the previous one.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : ntt_layer_ctrl_if master (start/stall in, issue/write/status out)
// rd_en_o is combinational from the state and stall_i so a stall removes the
// issue in the same cycle; the issue addresses themselves are registered.
module ntt_layer_ctrl #(
  parameter int LOG_N = 8,
  parameter int LAT   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  ntt_layer_ctrl_if.master  bus
);

  localparam int            BW         = LOG_N - 1;
  localparam logic [2:0]    LAST_LAYER = 3'(LOG_N - 2);
  localparam logic [BW-1:0] LAST_BF    = '1;
  localparam logic [3:0]    LAST_DRAIN = 4'(LAT - 1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  state_t        state, state_nxt;
  logic [2:0]    layer, layer_nxt;
  logic [BW-1:0] bf, bf_nxt;
  logic [3:0]    drain, drain_nxt;
  logic          issue;

  // next-state / counter logic
  always_comb begin
    state_nxt = state;
    layer_nxt = layer;
    bf_nxt    = bf;
    drain_nxt = drain;
    issue     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start_i) begin
          state_nxt = RUN;
          layer_nxt = '0;
          bf_nxt    = '0;
        end
      end
      RUN: begin
        if (!bus.stall_i) begin
          issue  = 1'b1;
          bf_nxt = bf + BW'(1);
          if (bf == LAST_BF) begin
            state_nxt = DRAIN;
            drain_nxt = '0;
          end
        end
      end
      DRAIN: begin
        if (drain == LAST_DRAIN) begin
          if (layer == LAST_LAYER) begin
            state_nxt = FIN;
          end else begin
            state_nxt = RUN;
            layer_nxt = layer + 3'd1;
            bf_nxt    = '0;
          end
        end else begin
          drain_nxt = drain + 4'd1;
        end
      end
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      layer <= '0;
      bf    <= '0;
      drain <= '0;
    end else begin
      state <= state_nxt;
      layer <= layer_nxt;
      bf    <= bf_nxt;
      drain <= drain_nxt;
    end
  end

  // Address arithmetic on the upcoming (layer, b) so the registered issue
  // fields line up with the cycle in which the butterfly is issued.
  int               shift;
  logic [LOG_N-1:0] bx, len, j;
  logic [LOG_N-1:0] ra_nxt, rb_nxt;
  logic [BW-1:0]    zeta_nxt;

  always_comb begin
    shift    = LOG_N - 1 - int'(layer_nxt);
    bx       = {1'b0, bf_nxt};
    len      = LOG_N'(1) << shift;
    j        = ((bx >> shift) << (shift + 1)) | (bx & (len - LOG_N'(1)));
    ra_nxt   = j;
    rb_nxt   = j + len;
    zeta_nxt = (BW'(1) << layer_nxt) + (bf_nxt >> shift);
  end

  logic [LOG_N-1:0] rd_a, rd_b;
  logic [BW-1:0]    zeta;
  logic [2:0]       layer_q;

  // Reloading during a stall rewrites the same values, so outside RUN
  // (and across stalls) the fields hold the last issued butterfly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_a    <= '0;
      rd_b    <= '0;
      zeta    <= '0;
      layer_q <= '0;
    end else if (state_nxt == RUN) begin
      rd_a    <= ra_nxt;
      rd_b    <= rb_nxt;
      zeta    <= zeta_nxt;
      layer_q <= layer_nxt;
    end
  end

  // Write-back delay line: shifts every cycle so stalls travel as bubbles.
  logic [LAT-1:0]   v_pipe;
  logic [LOG_N-1:0] a_pipe [LAT];
  logic [LOG_N-1:0] b_pipe [LAT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_pipe <= '0;
      for (int unsigned i = 0; i < LAT; i++) begin
        a_pipe[i] <= '0;
        b_pipe[i] <= '0;
      end
    end else begin
      v_pipe[0] <= issue;
      a_pipe[0] <= rd_a;
      b_pipe[0] <= rd_b;
      for (int unsigned i = 1; i < LAT; i++) begin
        v_pipe[i] <= v_pipe[i-1];
        a_pipe[i] <= a_pipe[i-1];
        b_pipe[i] <= b_pipe[i-1];
      end
    end
  end

  assign bus.busy_o      = (state == RUN) || (state == DRAIN);
  assign bus.done_o      = (state == FIN);
  assign bus.rd_en_o     = issue;
  assign bus.rd_addr_a_o = rd_a;
  assign bus.rd_addr_b_o = rd_b;
  assign bus.zeta_idx_o  = zeta;
  assign bus.layer_o     = layer_q;
  assign bus.wr_en_o     = v_pipe[LAT-1];
  assign bus.wr_addr_a_o = a_pipe[LAT-1];
  assign bus.wr_addr_b_o = b_pipe[LAT-1];

endmodule

// File: tb/tb_ntt_layer_ctrl.sv
// Bench for ntt_layer_ctrl: drives transforms, logs outputs per cycle
// (cycle 0 = cycle in which start_i is presented), and checks against an
// expected issue/write scoreboard plus a behavioural RAM + reference NTT.
module tb_ntt_layer_ctrl;
  localparam int LOG_N = 8;
  localparam int LAT   = 4;
  localparam int Q     = 3329;
  localparam int NB    = 128;
  localparam int NL    = 7;
  localparam int MAXC  = 1100;

  logic clk;
  logic rst_n;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  ntt_layer_ctrl_if #(.LOG_N(LOG_N)) bus ();
  ntt_layer_ctrl #(.LOG_N(LOG_N), .LAT(LAT)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  typedef struct {int cyc; int a; int b; int z; int l;} ev_t;
  typedef struct {int va; int vb;} pv_t;

  ev_t exp_iss[$];
  ev_t exp_wr[$];
  pv_t pend[$];

  int lg_rd[MAXC], lg_a[MAXC], lg_b[MAXC], lg_z[MAXC], lg_l[MAXC];
  int lg_wr[MAXC], lg_wa[MAXC], lg_wb[MAXC], lg_busy[MAXC];
  int done_cnt, done_cyc, rd_cnt, wr_cnt;
  int ram[256], ref_r[256], zetas[NB];
  int passed = 0;
  int total  = 0;

  task automatic init_zetas();
    int br, z;
    for (int i = 0; i < NB; i++) begin
      br = 0;
      for (int k = 0; k < 7; k++) if (((i >> k) & 1) != 0) br = br | (1 << (6 - k));
      z = 1;
      for (int k = 0; k < br; k++) z = (z * 17) % Q;
      zetas[i] = z;
    end
  endtask

  // random coefficients into the bench RAM and a textbook NTT of the same data
  task automatic load_vectors();
    int k, zt, t;
    for (int i = 0; i < 256; i++) begin
      ram[i]   = int'($urandom_range(0, Q - 1));
      ref_r[i] = ram[i];
    end
    k = 1;
    for (int len = 128; len >= 2; len = len >> 1) begin
      for (int st = 0; st < 256; st = st + 2 * len) begin
        zt = zetas[k];
        k++;
        for (int j = st; j < st + len; j++) begin
          t = (zt * ref_r[j + len]) % Q;
          ref_r[j + len] = (ref_r[j] + Q - t) % Q;
          ref_r[j]       = (ref_r[j] + t) % Q;
        end
      end
    end
  endtask

  // Drive one transform; push the expected issue/write stream when the
  // stimulus is set up, then log DUT outputs and run the RAM model.
  task automatic run(input int stall_at, input int stall_len, input int extra_start,
                     input int stop_at);
    ev_t e;
    pv_t pv;
    int s, len, j, base, t;
    exp_iss.delete();
    exp_wr.delete();
    pend.delete();
    for (int L = 0; L < NL; L++) begin
      for (int b = 0; b < NB; b++) begin
        s    = LOG_N - 1 - L;
        len  = 1 << s;
        j    = ((b >> s) << (s + 1)) | (b & (len - 1));
        base = 1 + L * (NB + LAT) + b;
        e.cyc = base + ((stall_len > 0 && base >= stall_at) ? stall_len : 0);
        e.a = j; e.b = j + len; e.z = (1 << L) + (b >> s); e.l = L;
        exp_iss.push_back(e);
        e.cyc = e.cyc + LAT;
        exp_wr.push_back(e);
      end
    end
    for (int c = 0; c < MAXC; c++) begin
      lg_rd[c] = 0; lg_a[c] = 0; lg_b[c] = 0; lg_z[c] = 0; lg_l[c] = 0;
      lg_wr[c] = 0; lg_wa[c] = 0; lg_wb[c] = 0; lg_busy[c] = 0;
    end
    done_cnt = 0; done_cyc = -1; rd_cnt = 0; wr_cnt = 0;
    for (int c = 0; c < MAXC; c++) begin
      @(posedge clk);
      #1;
      bus.start_i = (c == 0 || c == extra_start);
      bus.stall_i = (c >= stall_at && c < stall_at + stall_len);
      @(negedge clk);
      lg_rd[c] = int'(bus.rd_en_o);   lg_a[c]  = int'(bus.rd_addr_a_o);
      lg_b[c]  = int'(bus.rd_addr_b_o); lg_z[c] = int'(bus.zeta_idx_o);
      lg_l[c]  = int'(bus.layer_o);   lg_wr[c] = int'(bus.wr_en_o);
      lg_wa[c] = int'(bus.wr_addr_a_o); lg_wb[c] = int'(bus.wr_addr_b_o);
      lg_busy[c] = int'(bus.busy_o);
      if (bus.wr_en_o) begin
        wr_cnt++;
        if (pend.size() > 0) begin
          pv = pend.pop_front();
          ram[lg_wa[c]] = pv.va;
          ram[lg_wb[c]] = pv.vb;
        end
      end
      if (bus.rd_en_o) begin
        rd_cnt++;
        t = (zetas[lg_z[c]] * ram[lg_b[c]]) % Q;
        pv.va = (ram[lg_a[c]] + t) % Q;
        pv.vb = (ram[lg_a[c]] + Q - t) % Q;
        pend.push_back(pv);
      end
      if (bus.done_o) begin
        done_cnt++;
        done_cyc = c;
      end
      if (c == stop_at) break;
      if (done_cnt > 0 && c >= done_cyc + 3) break;
    end
    bus.start_i = 1'b0;
    bus.stall_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.start_i = 1'b0;
    bus.stall_i = 1'b0;
    #23;
    total += 10;
    if (bus.busy_o !== 1'b0) $display("FAIL rst_busy: got %b expected 0", bus.busy_o); else passed++;
    if (bus.done_o !== 1'b0) $display("FAIL rst_done: got %b expected 0", bus.done_o); else passed++;
    if (bus.rd_en_o !== 1'b0) $display("FAIL rst_rd_en: got %b expected 0", bus.rd_en_o); else passed++;
    if (bus.rd_addr_a_o !== '0) $display("FAIL rst_rd_a: got %0d expected 0", bus.rd_addr_a_o); else passed++;
    if (bus.rd_addr_b_o !== '0) $display("FAIL rst_rd_b: got %0d expected 0", bus.rd_addr_b_o); else passed++;
    if (bus.zeta_idx_o !== '0) $display("FAIL rst_zeta: got %0d expected 0", bus.zeta_idx_o); else passed++;
    if (bus.layer_o !== '0) $display("FAIL rst_layer: got %0d expected 0", bus.layer_o); else passed++;
    if (bus.wr_en_o !== 1'b0) $display("FAIL rst_wr_en: got %b expected 0", bus.wr_en_o); else passed++;
    if (bus.wr_addr_a_o !== '0) $display("FAIL rst_wr_a: got %0d expected 0", bus.wr_addr_a_o); else passed++;
    if (bus.wr_addr_b_o !== '0) $display("FAIL rst_wr_b: got %0d expected 0", bus.wr_addr_b_o); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_first_issue(input string tag);
    total += 12;
    if (lg_busy[0] !== 0) $display("FAIL %s_busy_c0: got %0d expected 0", tag, lg_busy[0]); else passed++;
    if (lg_busy[1] !== 1) $display("FAIL %s_busy_c1: got %0d expected 1", tag, lg_busy[1]); else passed++;
    if (lg_rd[0] !== 0) $display("FAIL %s_rd_c0: got %0d expected 0", tag, lg_rd[0]); else passed++;
    if (lg_rd[1] !== 1) $display("FAIL %s_rd_c1: got %0d expected 1", tag, lg_rd[1]); else passed++;
    if (lg_a[1] !== 0 || lg_b[1] !== 128) $display("FAIL %s_addr_c1: got a=%0d b=%0d expected a=0 b=128", tag, lg_a[1], lg_b[1]); else passed++;
    if (lg_z[1] !== 1 || lg_l[1] !== 0) $display("FAIL %s_zl_c1: got z=%0d l=%0d expected z=1 l=0", tag, lg_z[1], lg_l[1]); else passed++;
    if (lg_rd[2] !== 1) $display("FAIL %s_rd_c2: got %0d expected 1", tag, lg_rd[2]); else passed++;
    if (lg_a[2] !== 1 || lg_b[2] !== 129) $display("FAIL %s_addr_c2: got a=%0d b=%0d expected a=1 b=129", tag, lg_a[2], lg_b[2]); else passed++;
    if (lg_z[2] !== 1) $display("FAIL %s_zeta_c2: got %0d expected 1", tag, lg_z[2]); else passed++;
    if (lg_wr[4] !== 0) $display("FAIL %s_wr_c4: got %0d expected 0", tag, lg_wr[4]); else passed++;
    if (lg_wr[5] !== 1) $display("FAIL %s_wr_c5: got %0d expected 1", tag, lg_wr[5]); else passed++;
    if (lg_wa[5] !== 0 || lg_wb[5] !== 128) $display("FAIL %s_wr_addr_c5: got a=%0d b=%0d expected a=0 b=128", tag, lg_wa[5], lg_wb[5]); else passed++;
  endtask

  task automatic test_layer_boundary();
    total += 7;
    if (lg_rd[128] !== 1 || lg_a[128] !== 127 || lg_b[128] !== 255)
      $display("FAIL lb_last_issue: got rd=%0d a=%0d b=%0d expected rd=1 a=127 b=255", lg_rd[128], lg_a[128], lg_b[128]); else passed++;
    if (lg_wr[132] !== 1 || lg_wa[132] !== 127 || lg_wb[132] !== 255)
      $display("FAIL lb_last_write: got wr=%0d a=%0d b=%0d expected wr=1 a=127 b=255", lg_wr[132], lg_wa[132], lg_wb[132]); else passed++;
    for (int c = 129; c <= 132; c++)
      if (lg_rd[c] !== 0) $display("FAIL lb_drain_rd: cycle %0d got %0d expected 0", c, lg_rd[c]); else passed++;
    if (lg_rd[133] !== 1 || lg_a[133] !== 0 || lg_b[133] !== 64 || lg_z[133] !== 2 || lg_l[133] !== 1)
      $display("FAIL lb_layer1_first: got rd=%0d a=%0d b=%0d z=%0d l=%0d expected 1 0 64 2 1",
               lg_rd[133], lg_a[133], lg_b[133], lg_z[133], lg_l[133]); else passed++;
  endtask

  task automatic test_layer6();
    int cy[4];
    int ea[4];
    int eb[4];
    int ez[4];
    cy = '{793, 794, 795, 920};
    ea = '{0, 1, 4, 253};
    eb = '{2, 3, 6, 255};
    ez = '{64, 64, 65, 127};
    for (int i = 0; i < 4; i++) begin
      total++;
      if (lg_rd[cy[i]] !== 1 || lg_a[cy[i]] !== ea[i] || lg_b[cy[i]] !== eb[i] ||
          lg_z[cy[i]] !== ez[i] || lg_l[cy[i]] !== 6)
        $display("FAIL l6_issue_c%0d: got rd=%0d a=%0d b=%0d z=%0d l=%0d expected 1 %0d %0d %0d 6",
                 cy[i], lg_rd[cy[i]], lg_a[cy[i]], lg_b[cy[i]], lg_z[cy[i]], lg_l[cy[i]], ea[i], eb[i], ez[i]);
      else passed++;
    end
  endtask

  task automatic test_full_run();
    int hits[256];
    int bad;
    total += 8;
    if (done_cnt !== 1) $display("FAIL full_done_count: got %0d expected 1", done_cnt); else passed++;
    if (done_cyc !== 925) $display("FAIL full_done_cycle: got %0d expected 925", done_cyc); else passed++;
    if (lg_busy[924] !== 1) $display("FAIL full_busy_924: got %0d expected 1", lg_busy[924]); else passed++;
    if (lg_busy[925] !== 0) $display("FAIL full_busy_925: got %0d expected 0", lg_busy[925]); else passed++;
    if (lg_busy[301] !== 1) $display("FAIL full_busy_after_restart: got %0d expected 1", lg_busy[301]); else passed++;
    if (rd_cnt !== 896) $display("FAIL full_issue_count: got %0d expected 896", rd_cnt); else passed++;
    if (wr_cnt !== 896) $display("FAIL full_write_count: got %0d expected 896", wr_cnt); else passed++;
    for (int i = 0; i < 256; i++) hits[i] = 0;
    for (int c = 0; c < MAXC; c++)
      if (lg_wr[c] == 1) begin
        hits[lg_wa[c]]++;
        hits[lg_wb[c]]++;
      end
    bad = 0;
    for (int i = 0; i < 256; i++) if (hits[i] != 7) bad++;
    if (bad !== 0) $display("FAIL full_index_coverage: got %0d indices not written 7 times expected 0", bad); else passed++;
  endtask

  task automatic test_scoreboard(input string tag);
    ev_t e;
    for (int c = 0; c < MAXC; c++) begin
      if (lg_rd[c] == 1) begin
        total++;
        if (exp_iss.size() == 0) $display("FAIL %s_extra_issue: issue at cycle %0d expected none", tag, c);
        else begin
          e = exp_iss.pop_front();
          if (c !== e.cyc || lg_a[c] !== e.a || lg_b[c] !== e.b || lg_z[c] !== e.z || lg_l[c] !== e.l)
            $display("FAIL %s_issue: got cyc=%0d a=%0d b=%0d z=%0d l=%0d expected cyc=%0d a=%0d b=%0d z=%0d l=%0d",
                     tag, c, lg_a[c], lg_b[c], lg_z[c], lg_l[c], e.cyc, e.a, e.b, e.z, e.l);
          else passed++;
        end
      end
      if (lg_wr[c] == 1) begin
        total++;
        if (exp_wr.size() == 0) $display("FAIL %s_extra_write: write at cycle %0d expected none", tag, c);
        else begin
          e = exp_wr.pop_front();
          if (c !== e.cyc || lg_wa[c] !== e.a || lg_wb[c] !== e.b)
            $display("FAIL %s_write: got cyc=%0d a=%0d b=%0d expected cyc=%0d a=%0d b=%0d",
                     tag, c, lg_wa[c], lg_wb[c], e.cyc, e.a, e.b);
          else passed++;
        end
      end
    end
    total += 2;
    if (exp_iss.size() != 0) $display("FAIL %s_missing_issues: got %0d left expected 0", tag, exp_iss.size()); else passed++;
    if (exp_wr.size() != 0) $display("FAIL %s_missing_writes: got %0d left expected 0", tag, exp_wr.size()); else passed++;
  endtask

  task automatic test_ntt_result(input string tag);
    for (int i = 0; i < 256; i++) begin
      total++;
      if (ram[i] !== ref_r[i]) $display("FAIL %s_ntt_coef%0d: got %0d expected %0d", tag, i, ram[i], ref_r[i]);
      else passed++;
    end
  endtask

  task automatic test_stall();
    total += 8;
    for (int c = 10; c <= 12; c++)
      if (lg_rd[c] !== 0) $display("FAIL st_rd_c%0d: got %0d expected 0", c, lg_rd[c]); else passed++;
    if (lg_rd[13] !== 1 || lg_a[13] !== 9 || lg_b[13] !== 137)
      $display("FAIL st_resume: got rd=%0d a=%0d b=%0d expected 1 9 137", lg_rd[13], lg_a[13], lg_b[13]); else passed++;
    if (lg_wr[14] !== 0 || lg_wr[15] !== 0 || lg_wr[16] !== 0)
      $display("FAIL st_bubbles: got %0d%0d%0d expected 000", lg_wr[14], lg_wr[15], lg_wr[16]); else passed++;
    if (lg_wr[17] !== 1 || lg_wa[17] !== 9)
      $display("FAIL st_wr_resume: got wr=%0d a=%0d expected 1 9", lg_wr[17], lg_wa[17]); else passed++;
    if (done_cnt !== 1) $display("FAIL st_done_count: got %0d expected 1", done_cnt); else passed++;
    if (done_cyc !== 928) $display("FAIL st_done_cycle: got %0d expected 928", done_cyc); else passed++;
  endtask

  task automatic test_abort();
    int seen;
    run(0, 0, -1, 400);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    total += 6;
    if (lg_busy[400] !== 1) $display("FAIL ab_busy_before: got %0d expected 1", lg_busy[400]); else passed++;
    if (bus.busy_o !== 1'b0 || bus.done_o !== 1'b0 || bus.rd_en_o !== 1'b0 || bus.wr_en_o !== 1'b0)
      $display("FAIL ab_strobes: got busy=%b done=%b rd=%b wr=%b expected 0000",
               bus.busy_o, bus.done_o, bus.rd_en_o, bus.wr_en_o); else passed++;
    if (bus.rd_addr_a_o !== '0 || bus.rd_addr_b_o !== '0 || bus.zeta_idx_o !== '0 || bus.layer_o !== '0)
      $display("FAIL ab_rd_fields: got a=%0d b=%0d z=%0d l=%0d expected 0 0 0 0",
               bus.rd_addr_a_o, bus.rd_addr_b_o, bus.zeta_idx_o, bus.layer_o); else passed++;
    if (bus.wr_addr_a_o !== '0 || bus.wr_addr_b_o !== '0)
      $display("FAIL ab_wr_fields: got a=%0d b=%0d expected 0 0", bus.wr_addr_a_o, bus.wr_addr_b_o); else passed++;
    seen = done_cnt;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.done_o === 1'b1) seen++;
    end
    if (seen !== 0) $display("FAIL ab_no_done: got %0d done pulses expected 0", seen); else passed++;
    if (bus.busy_o !== 1'b0) $display("FAIL ab_busy_held: got %b expected 0", bus.busy_o); else passed++;
    rst_n = 1'b1;
    run(0, 0, -1, 8);
    test_first_issue("restart");
  endtask

  initial begin
    init_zetas();
    test_reset();

    load_vectors();
    run(0, 0, 300, -1);
    test_first_issue("first");
    test_layer_boundary();
    test_layer6();
    test_full_run();
    test_scoreboard("nostall");
    test_ntt_result("nostall");

    load_vectors();
    run(10, 3, -1, -1);
    test_stall();
    test_scoreboard("stall");
    test_ntt_result("stall");

    test_abort();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/ntt_layer_ctrl.md
Name: ntt_layer_ctrl

Overview:
- Sequencer for the in-place forward NTT (Q = 3329, N = 256, 12-bit coefficients).
- Drives one shared, pipelined Cooley-Tukey butterfly unit (modular multiplier plus mod adder/subtractor) and the dual-port coefficient RAM.
- Walks 7 layers × 128 butterflies.
- Generates read addresses, twiddle index and delayed write-back addresses, and drains the pipeline between layers to avoid RAW hazards.

Parameters:
- LOG_N, 8: log2 of coefficient count. Layers = LOG_N-1; butterflies per layer = 2^(LOG_N-1).
- LAT, 4: cycles from rd_en_o to the matching wr_en_o (RAM read plus butterfly). Legal range 1..15.

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start_i  in  1  begin a transform; sampled only in IDLE
- stall_i  in  1  suppress issue this cycle (RUN state only)
- busy_o  out  1  high from the cycle after start is accepted until done_o
- done_o  out  1  one-cycle pulse at completion
- rd_en_o  out  1  butterfly issue strobe
- rd_addr_a_o  out  LOG_N  top operand index j
- rd_addr_b_o  out  LOG_N  bottom operand index j+len
- zeta_idx_o  out  LOG_N-1  twiddle ROM index
- layer_o  out  3  current layer, 0..LOG_N-2
- wr_en_o  out  1  write-back strobe
- wr_addr_a_o  out  LOG_N  write index for result a'
- wr_addr_b_o  out  LOG_N  write index for result b'

Behaviour:
- Reset (async, rst_n=0):
  - All outputs 0; FSM to IDLE.
  - Layer counter, butterfly counter and write-delay pipeline cleared.
  - Reset mid-transform aborts immediately; no done_o is produced.
- FSM states: IDLE, RUN, DRAIN, FIN.
  - IDLE: start_i=1 → RUN next cycle; busy_o=1; layer=0; b=0.
  - RUN:
    - stall_i=0: rd_en_o=1 and b increments.
    - stall_i=1: rd_en_o=0; counters hold.
    - Issue with b=127 → DRAIN.
  - DRAIN:
    - Exactly LAT cycles; stall_i ignored; rd_en_o=0.
    - Then, if layer < LOG_N-2: layer+1, b=0, → RUN.
    - Otherwise → FIN.
  - FIN: one cycle; done_o=1, busy_o=0; → IDLE.
  - start_i while busy_o=1 is ignored. start_i in FIN is ignored.
- Address arithmetic, combinational from (layer, b):
  - s = LOG_N-1-layer; len = 2^s.
  - j = ((b >> s) << (s+1)) | (b & (len-1)).
  - rd_addr_a_o = j; rd_addr_b_o = j+len.
  - zeta_idx_o = 2^layer + (b >> s). Range 1..127; 0 is never issued.
- rd_addr_*, zeta_idx_o and layer_o are registered and valid only while rd_en_o=1. Otherwise they hold their last value.
- Write pipeline:
  - LAT-deep shift register of {valid, addr_a, addr_b}; shifts every cycle, including during stall.
  - wr_en_o and wr_addr_* equal the rd_en_o/rd_addr_* from exactly LAT cycles earlier.
  - Stalls propagate as bubbles.
- No-stall timing (start sampled at cycle 0):
  - First issue at cycle 1.
  - Layer L issues in cycles 1+L·(128+LAT) .. 128+L·(128+LAT).
  - done_o at cycle 7·(128+LAT)+1 (925 for LAT=4).
- Each transform performs exactly 896 issues and 896 writes. Every index 0..255 appears exactly 7 times across wr_addr_a_o/wr_addr_b_o.

Test Plan:
- Start after reset, LAT=4 → cycle 1: rd_en=1, a=0, b=128, zeta=1, layer=0; cycle 2: a=1, b=129, zeta=1; cycle 5: wr_en=1, wr_a=0, wr_b=128.
- Layer 0→1 boundary → last issue at cycle 128 (a=127, b=255); last write at 132; rd_en=0 for cycles 129–132; cycle 133: a=0, b=64, zeta=2, layer=1.
- Layer 6 check → b=0: a=0, b=2, zeta=64; b=1: a=1, b=3, zeta=64; b=2: a=4, b=6, zeta=65; b=127: a=253, b=255, zeta=127.
- stall_i high for 3 cycles at cycle 10 → rd_en=0 for those cycles; the issue after the stall continues at a=9, b=137; matching wr_en bubbles appear at cycles 14–16; done_o moves to cycle 928.
- Full run → done_o pulses once at cycle 925; busy_o falls the same cycle; 896 wr_en pulses counted; start_i pulsed at cycle 300 has no effect; reference-model NTT of RAM matches.
- rst_n low at cycle 400 → all outputs 0 asynchronously; no done_o; a new start after release produces the cycle-1 sequence of scenario 1.
